// File: rtl/sram_sp_arb2_pkg.sv
// rtl/sram_sp_arb2_pkg.sv - shared constants and helpers for the two-requester SRAM arbiter
package sram_sp_arb2_pkg;

  localparam int ID_WD  = 1;
  localparam int CNT_WD = 16;

  // Number of address bits needed to index n words (ceil(log2(n))).
  function automatic int func_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_sp_reg_based.sv
// rtl/sram_sp_reg_based.sv - single-port register-array SRAM with optional output register
module sram_sp_reg_based
  import sram_sp_arb2_pkg::*;
#(
  parameter int  KNOB_REGOUT = 0,
  parameter int  SIZE        = 8,
  parameter int  DATA_WD     = 16,
  localparam int SIZE_WD     = func_log2(SIZE)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [SIZE_WD-1:0] adr_i,
  input  logic               wr_val_i,
  input  logic [DATA_WD-1:0] wr_dat_i,
  input  logic               rd_val_i,
  output logic               rd_val_o,
  output logic [DATA_WD-1:0] rd_dat_o
);

  logic [DATA_WD-1:0] mem [SIZE];
  logic               rd_val_q;
  logic [DATA_WD-1:0] rd_dat_q;

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_val_i) mem[adr_i] <= wr_dat_i;
    if (rd_val_i) rd_dat_q <= mem[adr_i];
  end

  always_ff @(posedge clk) begin
    if (!rstn) rd_val_q <= 1'b0;
    else       rd_val_q <= rd_val_i;
  end

  generate
    if (KNOB_REGOUT != 0) begin : g_regout
      logic               rd_val_q2;
      logic [DATA_WD-1:0] rd_dat_q2;

      always_ff @(posedge clk) begin
        if (!rstn) rd_val_q2 <= 1'b0;
        else       rd_val_q2 <= rd_val_q;
        if (rd_val_q) rd_dat_q2 <= rd_dat_q;
      end

      assign rd_val_o = rd_val_q2;
      assign rd_dat_o = rd_dat_q2;
    end else begin : g_direct
      assign rd_val_o = rd_val_q;
      assign rd_dat_o = rd_dat_q;
    end
  endgenerate

endmodule

// File: rtl/sram_sp_arb2.sv
// rtl/sram_sp_arb2.sv - round-robin two-requester arbiter and response router for one SRAM
module sram_sp_arb2
  import sram_sp_arb2_pkg::*;
#(
  parameter int  KNOB_REGOUT = 0,
  parameter int  SIZE        = 8,
  parameter int  DATA_WD     = 16,
  localparam int SIZE_WD     = func_log2(SIZE)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               req0_val_i,
  output logic               req0_rdy_o,
  input  logic               req0_wr_i,
  input  logic [SIZE_WD-1:0] req0_adr_i,
  input  logic [DATA_WD-1:0] req0_dat_i,
  output logic               rsp0_val_o,
  output logic [DATA_WD-1:0] rsp0_dat_o,
  input  logic               req1_val_i,
  output logic               req1_rdy_o,
  input  logic               req1_wr_i,
  input  logic [SIZE_WD-1:0] req1_adr_i,
  input  logic [DATA_WD-1:0] req1_dat_i,
  output logic               rsp1_val_o,
  output logic [DATA_WD-1:0] rsp1_dat_o,
  output logic [CNT_WD-1:0]  cnt_cfl_o
);

  localparam int L = 1 + KNOB_REGOUT;

  logic               pri_r;
  logic               gnt0;
  logic               gnt1;
  logic               xfer;
  logic [ID_WD-1:0]   gnt_id;
  logic               gnt_wr;
  logic               conflict;

  logic [SIZE_WD-1:0] sram_adr;
  logic [DATA_WD-1:0] sram_wr_dat;
  logic [DATA_WD-1:0] sram_rd_dat;
  logic               sram_wr_val;
  logic               sram_rd_val;
  logic               sram_rd_val_unused;

  logic [L-1:0]       tag_val;
  logic [ID_WD-1:0]   tag_id [L];
  logic [CNT_WD-1:0]  cnt_r;

  assign conflict = req0_val_i & req1_val_i;

  // Grants are suppressed entirely while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rstn) begin
      if (conflict) begin
        gnt0 = ~pri_r;
        gnt1 = pri_r;
      end else begin
        gnt0 = req0_val_i;
        gnt1 = req1_val_i;
      end
    end
  end

  assign req0_rdy_o = gnt0;
  assign req1_rdy_o = gnt1;
  assign xfer       = gnt0 | gnt1;
  assign gnt_id     = ID_WD'(gnt1);

  assign gnt_wr      = gnt1 ? req1_wr_i  : req0_wr_i;
  assign sram_adr    = gnt1 ? req1_adr_i : req0_adr_i;
  assign sram_wr_dat = gnt1 ? req1_dat_i : req0_dat_i;
  assign sram_wr_val = xfer & gnt_wr;
  assign sram_rd_val = xfer & ~gnt_wr;

  always_ff @(posedge clk) begin
    if (!rstn)     pri_r <= 1'b0;
    else if (xfer) pri_r <= ~gnt1;
  end

  // Tag pipeline depth matches SRAM read latency so the last stage lines up with rd_dat_o.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tag_val <= '0;
    end else begin
      tag_val[0] <= sram_rd_val;
      for (int i = 1; i < L; i++) tag_val[i] <= tag_val[i-1];
    end
    tag_id[0] <= gnt_id;
    for (int i = 1; i < L; i++) tag_id[i] <= tag_id[i-1];
  end

  assign rsp0_val_o = tag_val[L-1] & (tag_id[L-1] == ID_WD'(0));
  assign rsp1_val_o = tag_val[L-1] & (tag_id[L-1] == ID_WD'(1));
  assign rsp0_dat_o = rsp0_val_o ? sram_rd_dat : '0;
  assign rsp1_dat_o = rsp1_val_o ? sram_rd_dat : '0;

  always_ff @(posedge clk) begin
    if (!rstn)
      cnt_r <= '0;
    else if (conflict && (cnt_r != {CNT_WD{1'b1}}))
      cnt_r <= cnt_r + CNT_WD'(1);
  end

  assign cnt_cfl_o = cnt_r;

  sram_sp_reg_based #(
    .KNOB_REGOUT (KNOB_REGOUT),
    .SIZE        (SIZE),
    .DATA_WD     (DATA_WD)
  ) u_sram (
    .clk      (clk),
    .rstn     (rstn),
    .adr_i    (sram_adr),
    .wr_val_i (sram_wr_val),
    .wr_dat_i (sram_wr_dat),
    .rd_val_i (sram_rd_val),
    .rd_val_o (sram_rd_val_unused),
    .rd_dat_o (sram_rd_dat)
  );

endmodule
